// File: rtl/traffic_phase_scheduler.sv
// Sensor-actuated two-approach phase controller with min/max green, yellow and all-red timing.
// Define PED_PHASE_EN to compile in the pedestrian walk phase and its latched request.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       ped_req,
    output logic [2:0] LightA,
    output logic [2:0] LightB,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        WALK  = 3'd6
    } state_e;

    localparam logic [2:0] LAMP_GRN = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_RED = 3'b001;

    localparam logic [CNT_W:0] GMIN = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0] GMAX = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0] YEL  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] ALLR = (CNT_W+1)'(ALLRED_T);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   el;
    logic             ped_dem;

`ifdef PED_PHASE_EN
    localparam logic [CNT_W:0] WLK = (CNT_W+1)'(WALK_T);

    logic nxt_dir_q, nxt_dir_d;   // 1 = B is served after the walk
    logic ped_pending_q, ped_pending_d;

    assign ped_dem = ped_pending_q;
`else
    logic unused_ped;

    assign unused_ped = ped_req ^ (WALK_T > 0);
    assign ped_dem    = 1'b0;
`endif

    // Elapsed ticks including the current one; one bit wider so a saturated cnt never wraps.
    assign el = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= A_GRN;
            cnt_q   <= '0;
`ifdef PED_PHASE_EN
            nxt_dir_q     <= 1'b0;
            ped_pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef PED_PHASE_EN
            nxt_dir_q     <= nxt_dir_d;
            ped_pending_q <= ped_pending_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GRN: if (tick && (sens_b || ped_dem) && ((el >= GMIN && !sens_a) || el >= GMAX))
                       state_d = A_YEL;
            A_YEL: if (tick && el == YEL) state_d = AR_AB;
            AR_AB: if (tick && el == ALLR) begin
`ifdef PED_PHASE_EN
                       state_d = ped_pending_q ? WALK : B_GRN;
`else
                       state_d = B_GRN;
`endif
                   end
            B_GRN: if (tick && (sens_a || ped_dem) && ((el >= GMIN && !sens_b) || el >= GMAX))
                       state_d = B_YEL;
            B_YEL: if (tick && el == YEL) state_d = AR_BA;
            AR_BA: if (tick && el == ALLR) begin
`ifdef PED_PHASE_EN
                       state_d = ped_pending_q ? WALK : A_GRN;
`else
                       state_d = A_GRN;
`endif
                   end
`ifdef PED_PHASE_EN
            WALK:  if (tick && el == WLK) state_d = nxt_dir_q ? B_GRN : A_GRN;
`endif
            default: state_d = A_GRN;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (tick)
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

`ifdef PED_PHASE_EN
        nxt_dir_d = nxt_dir_q;
        if (state_q == AR_AB && state_d != AR_AB)
            nxt_dir_d = 1'b1;
        else if (state_q == AR_BA && state_d != AR_BA)
            nxt_dir_d = 1'b0;

        // A press on the walk-entry edge wins over the clear.
        if (ped_req)
            ped_pending_d = 1'b1;
        else if (state_d == WALK && state_q != WALK)
            ped_pending_d = 1'b0;
        else
            ped_pending_d = ped_pending_q;
`endif
    end

    always_comb begin
        LightA = LAMP_RED;
        LightB = LAMP_RED;
        walk   = 1'b0;
        case (state_q)
            A_GRN: LightA = LAMP_GRN;
            A_YEL: LightA = LAMP_YEL;
            B_GRN: LightB = LAMP_GRN;
            B_YEL: LightB = LAMP_YEL;
`ifdef PED_PHASE_EN
            WALK:  walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase = state_q;
`ifdef PED_PHASE_EN
    assign ped_pending = ped_pending_q;
`else
    assign ped_pending = 1'b0;
`endif

endmodule
